// File: rtl/rx_cpl_host_mem.sv
// CplD receive path: validates completions, realigns 3DW payload to QWs.
// Optional CPL_TAG_CHECK_EN enables the completion tag compare.
module rx_cpl_host_mem #(
  parameter int CHUNK_DW = 128
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] trn_rd,
  input  logic [7:0]  trn_rrem_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rdst_rdy_n,
  input  logic        chunk_arm,
  input  logic [3:0]  chunk_tag,
  output logic        buf_wr_en,
  output logic [5:0]  buf_wr_addr,
  output logic [63:0] buf_wr_data,
  output logic        chunk_ready,
  input  logic        chunk_consumed,
  output logic        cpl_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    HDR1,
    DATA,
    DISCARD,
    DONE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [7:0]  dw_cnt;
  logic [5:0]  qw_ptr;
  logic [31:0] hold;

  logic beat;
  logic sof;
  logic eof;
  logic is_cpld;
  logic hdr_bad;
  logic tag_bad;
  logic last_ok;
  logic cnt_full;
  logic wr_d;
  logic err_d;
  logic ready_d;
  logic unused_sig;

  assign beat    = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign sof     = beat && !trn_rsof_n;
  assign eof     = beat && !trn_reof_n;
  assign is_cpld = trn_rd[62:56] == 7'b10_01010;
  assign last_ok = trn_rrem_n == 8'h0F;

  assign hdr_bad = (trn_rd[15:13] != 3'd0)
                || trn_rd[32]
                || (trn_rd[41:32] == 10'd0)
                || (({3'd0, dw_cnt} + {1'b0, trn_rd[41:32]})
                    > 11'(CHUNK_DW));

  assign cnt_full = ({1'b0, dw_cnt} + 9'd2) == 9'(CHUNK_DW);

`ifdef CPL_TAG_CHECK_EN
  logic [3:0] tag;

  always_ff @(posedge trn_clk) begin
    if (!reset_n) begin
      tag <= 4'd0;
    end else if (state == IDLE && chunk_arm) begin
      tag <= chunk_tag;
    end
  end

  assign tag_bad    = trn_rd[43:40] != tag;
  assign unused_sig = ^{trn_rd, trn_rrem_n};
`else
  assign tag_bad    = 1'b0;
  assign unused_sig = ^{trn_rd, trn_rrem_n, chunk_tag};
`endif

  always_ff @(posedge trn_clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (chunk_arm) nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (sof && is_cpld) nxt = hdr_bad ? DISCARD : HDR1;
      end
      HDR1: begin
        if (eof) nxt = WAIT_SOF;
        else if (beat) nxt = tag_bad ? DISCARD : DATA;
      end
      DATA: begin
        if (eof) nxt = (last_ok && cnt_full) ? DONE : WAIT_SOF;
      end
      DISCARD: begin
        if (eof) nxt = WAIT_SOF;
      end
      DONE: begin
        if (chunk_consumed) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_d    = 1'b0;
    err_d   = 1'b0;
    ready_d = 1'b0;
    unique case (state)
      IDLE: begin
        err_d = sof && is_cpld;
      end
      WAIT_SOF: begin
        err_d = sof && is_cpld && hdr_bad;
      end
      HDR1: begin
        err_d = beat && (eof || tag_bad);
      end
      DATA: begin
        wr_d  = beat && !(eof && !last_ok);
        err_d = eof && !last_ok;
      end
      DISCARD: begin
        err_d = 1'b0;
      end
      DONE: begin
        err_d   = sof && is_cpld;
        ready_d = !chunk_consumed;
      end
      default: begin
        err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge trn_clk) begin
    if (!reset_n) begin
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= 6'd0;
      buf_wr_data <= 64'd0;
      chunk_ready <= 1'b0;
      cpl_err     <= 1'b0;
      dw_cnt      <= 8'd0;
      qw_ptr      <= 6'd0;
      hold        <= 32'd0;
    end else begin
      buf_wr_en   <= wr_d;
      chunk_ready <= ready_d;
      cpl_err     <= err_d;
      if (state == IDLE && chunk_arm) begin
        dw_cnt <= 8'd0;
        qw_ptr <= 6'd0;
      end
      if (state == HDR1 && beat) begin
        hold <= trn_rd[31:0];
      end
      // Pair the carried DW with the upper DW of this beat.
      if (wr_d) begin
        buf_wr_addr <= qw_ptr;
        buf_wr_data <= {trn_rd[63:32], hold};
        hold        <= trn_rd[31:0];
        qw_ptr      <= qw_ptr + 6'd1;
        dw_cnt      <= dw_cnt + 8'd2;
      end
    end
  end

endmodule

// File: tb/tb_rx_cpl_host_mem.sv
// Directed bench for rx_cpl_host_mem with a write scoreboard.
// Build with or without CPL_TAG_CHECK_EN.
module tb_rx_cpl_host_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rdst_rdy_n;
  logic        chunk_arm;
  logic [3:0]  chunk_tag;
  logic        buf_wr_en;
  logic [5:0]  buf_wr_addr;
  logic [63:0] buf_wr_data;
  logic        chunk_ready;
  logic        chunk_consumed;
  logic        cpl_err;

  int n_vec = 0;
  int n_bad = 0;
  int n_err = 0;
  int e0;
  logic [5:0]  exp_qw;
  logic [69:0] sb[$];

  always #5 clk = ~clk;

  rx_cpl_host_mem #(.CHUNK_DW(128)) dut (
    .trn_clk(clk),
    .reset_n(reset_n),
    .trn_rd(trn_rd),
    .trn_rrem_n(trn_rrem_n),
    .trn_rsof_n(trn_rsof_n),
    .trn_reof_n(trn_reof_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n),
    .chunk_arm(chunk_arm),
    .chunk_tag(chunk_tag),
    .buf_wr_en(buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data),
    .chunk_ready(chunk_ready),
    .chunk_consumed(chunk_consumed),
    .cpl_err(cpl_err)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (buf_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected none",
                 buf_wr_addr, buf_wr_data);
      end else begin
        logic [69:0] e;
        e = sb.pop_front();
        chk("wr_addr", 64'(buf_wr_addr), 64'(e[69:64]));
        chk("wr_data", buf_wr_data, e[63:0]);
      end
    end
    if (cpl_err === 1'b1) n_err++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [63:0] d, input logic sof,
                     input logic eof, input logic [7:0] rem,
                     input bit stall);
    trn_rd         = d;
    trn_rsof_n     = !sof;
    trn_reof_n     = !eof;
    trn_rrem_n     = rem;
    trn_rsrc_rdy_n = 1'b0;
    if (stall) begin
      trn_rdst_rdy_n = 1'b1;
      tick();
      trn_rdst_rdy_n = 1'b0;
    end
    tick();
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
  endtask

  task automatic gap();
    trn_rd         = '1;
    trn_rsof_n     = 1'b0;
    trn_reof_n     = 1'b0;
    trn_rrem_n     = 8'h00;
    trn_rsrc_rdy_n = 1'b1;
    tick();
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
  endtask

  task automatic cpl(input logic [3:0] tg, input logic [9:0] len,
                     input logic [2:0] st, input logic [31:0] base,
                     input bit gaps, input bit good);
    logic [31:0] dw0, dw1, dw2, dj, dn, dp;
    dw0 = {1'b0, 7'b10_01010, 14'd0, len};
    dw1 = {16'h0100, st, 13'd0};
    dw2 = {20'h0, tg, 8'h00};
    put({dw0, dw1}, 1'b1, 1'b0, 8'h00, 1'b0);
    put({dw2, base}, 1'b0, 1'b0, 8'h00, gaps);
    for (int j = 1; j < int'(len); j += 2) begin
      dj = base + 32'(j);
      dn = base + 32'(j + 1);
      dp = base + 32'(j - 1);
      if (good) begin
        sb.push_back({exp_qw, dj, dp});
        exp_qw++;
      end
      if (gaps && (j % 4 == 1)) gap();
      if (j >= int'(len) - 1)
        put({dj, 32'h0}, 1'b0, 1'b1, 8'h0F, 1'b0);
      else
        put({dj, dn}, 1'b0, 1'b0, 8'h00, gaps && (j % 6 == 3));
    end
  endtask

  task automatic mwr();
    put({1'b0, 7'b10_00000, 14'd0, 10'd2, 32'h0000_00FF},
        1'b1, 1'b0, 8'h00, 1'b0);
    put({32'h1000_0000, 32'hAAAA_0000}, 1'b0, 1'b0, 8'h00, 1'b0);
    put({32'hAAAA_0001, 32'h0}, 1'b0, 1'b1, 8'h0F, 1'b0);
  endtask

  task automatic arm(input logic [3:0] tg);
    chunk_arm = 1'b1;
    chunk_tag = tg;
    tick();
    chunk_arm = 1'b0;
    exp_qw    = 6'd0;
  endtask

  task automatic finish_chunk(input string nm);
    chk({nm, "_ready_n1"}, 64'(chunk_ready), 64'd0);
    tick();
    chk({nm, "_ready_n2"}, 64'(chunk_ready), 64'd1);
    chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic consume();
    chunk_consumed = 1'b1;
    tick();
    chunk_consumed = 1'b0;
    chk("consume_drop", 64'(chunk_ready), 64'd0);
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    trn_rd         = 64'd0;
    trn_rrem_n     = 8'h00;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rdst_rdy_n = 1'b0;
    chunk_arm      = 1'b0;
    chunk_tag      = 4'd0;
    chunk_consumed = 1'b0;
    exp_qw         = 6'd0;
    repeat (2) tick();
    chk("rst_wr_en", 64'(buf_wr_en), 64'd0);
    chk("rst_addr", 64'(buf_wr_addr), 64'd0);
    chk("rst_data", buf_wr_data, 64'd0);
    chk("rst_ready", 64'(chunk_ready), 64'd0);
    chk("rst_err", 64'(cpl_err), 64'd0);
    reset_n = 1'b1;
    tick();

    arm(4'd3);
    cpl(4'd3, 10'd128, 3'd0, 32'd0, 1'b0, 1'b1);
    finish_chunk("full");
    e0 = n_err;
    chunk_arm = 1'b1;
    tick();
    chunk_arm = 1'b0;
    cpl(4'd3, 10'd2, 3'd0, 32'd0, 1'b0, 1'b0);
    settle();
    chk("done_cpl_err", 64'(n_err), 64'(e0 + 1));
    chk("done_hold", 64'(chunk_ready), 64'd1);
    consume();

    arm(4'd3);
    e0 = n_err;
    for (int i = 0; i < 8; i++) begin
      cpl(4'd3, 10'd16, 3'd0, 32'(16 * i), bit'(i % 2), 1'b1);
      if (i < 7) begin
        tick();
        chk("split_not_ready", 64'(chunk_ready), 64'd0);
      end
    end
    finish_chunk("split");
    chk("split_no_err", 64'(n_err), 64'(e0));
    consume();

    arm(4'd3);
    e0 = n_err;
    cpl(4'd3, 10'd128, 3'b001, 32'd0, 1'b0, 1'b0);
    settle();
    chk("ur_err", 64'(n_err), 64'(e0 + 1));
    cpl(4'd3, 10'd128, 3'd0, 32'd0, 1'b0, 1'b1);
    finish_chunk("after_ur");
    consume();

    arm(4'd3);
    e0 = n_err;
`ifdef CPL_TAG_CHECK_EN
    cpl(4'd5, 10'd128, 3'd0, 32'd0, 1'b0, 1'b0);
    settle();
    chk("tag_err", 64'(n_err), 64'(e0 + 1));
    cpl(4'd3, 10'd128, 3'd0, 32'd0, 1'b0, 1'b1);
`else
    cpl(4'd5, 10'd128, 3'd0, 32'd0, 1'b0, 1'b1);
`endif
    finish_chunk("tag");
`ifndef CPL_TAG_CHECK_EN
    chk("tag_no_err", 64'(n_err), 64'(e0));
`endif
    consume();

    arm(4'd3);
    e0 = n_err;
    cpl(4'd3, 10'd64, 3'd0, 32'd0, 1'b0, 1'b1);
    mwr();
    cpl(4'd3, 10'd128, 3'd0, 32'd64, 1'b0, 1'b0);
    mwr();
    tick();
    chk("mix_not_ready", 64'(chunk_ready), 64'd0);
    cpl(4'd3, 10'd64, 3'd0, 32'd64, 1'b1, 1'b1);
    finish_chunk("mix");
    chk("mix_ovf_err", 64'(n_err), 64'(e0 + 1));
    consume();

    arm(4'd3);
    cpl(4'd3, 10'd40, 3'd0, 32'd0, 1'b0, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("mrst_wr_en", 64'(buf_wr_en), 64'd0);
    chk("mrst_addr", 64'(buf_wr_addr), 64'd0);
    chk("mrst_data", buf_wr_data, 64'd0);
    chk("mrst_ready", 64'(chunk_ready), 64'd0);
    chk("mrst_err", 64'(cpl_err), 64'd0);
    reset_n = 1'b1;
    tick();
    e0 = n_err;
    cpl(4'd3, 10'd2, 3'd0, 32'd0, 1'b0, 1'b0);
    settle();
    chk("idle_cpl_err", 64'(n_err), 64'(e0 + 1));
    arm(4'd3);
    cpl(4'd3, 10'd128, 3'd0, 32'd0, 1'b0, 1'b1);
    finish_chunk("rearm");
    consume();
    settle();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_cpl_host_mem.md
# rx_cpl_host_mem

Consumes Completion-with-Data TLPs returned for the 512-byte (128 DW) host-memory read requests issued by the TX read-request stage. It snoops the 64-bit TRN receive stream, validates each CplD, realigns the 3DW-header payload to 64-bit words, and writes it into a 64 x 64-bit chunk buffer. It signals `chunk_ready` when the full chunk has landed and holds it until the consumer releases it.

## Interface
Parameters:
- `CHUNK_DW`, 128: DWs per chunk. Must be even. Buffer depth is `CHUNK_DW/2` QWs.

Ports:
- `trn_clk` in 1: single clock.
- `reset_n` in 1: reset; one clock; reset is synchronous and active-low.
- `trn_rd` in 64: RX data; `[63:32]` carries the earlier DW.
- `trn_rrem_n` in 8: `8'h00` means both DWs are valid; `8'h0F` means only `[63:32]` is valid.
- `trn_rsof_n`, `trn_reof_n` in 1 each: start and end of TLP, active-low.
- `trn_rsrc_rdy_n`, `trn_rdst_rdy_n` in 1 each: a beat transfers when both are low. The block never drives `trn_rdst_rdy_n`.
- `chunk_arm` in 1: pulse, one read request issued. Driven from `read_chunk_ack`.
- `chunk_tag` in 4: expected tag, sampled on `chunk_arm`.
- `buf_wr_en` out 1: buffer write strobe.
- `buf_wr_addr` out 6: QW index.
- `buf_wr_data` out 64: `[31:0]` = data DW 2k, `[63:32]` = data DW 2k+1.
- `chunk_ready` out 1: level, chunk complete.
- `chunk_consumed` in 1: pulse, consumer releases the chunk.
- `cpl_err` out 1: one-cycle pulse, a CplD was rejected.

## Operation
States:
- **IDLE**
  - `chunk_arm` latches the tag, clears `dw_cnt` (8 bit) and `qw_ptr` (6 bit), then goes to **WAIT_SOF**.
  - A CplD arriving in IDLE or DONE is ignored and raises `cpl_err`.
- **WAIT_SOF**: on a SOF beat, QW0 is checked:
  - fmt/type in `[62:56]` must be `7'b10_01010`; any other type is ignored silently and the state holds.
  - CplD with status `[15:13]` ≠ 0, length `[41:32]` odd or zero, or `dw_cnt` + length > `CHUNK_DW`: go to **DISCARD** and raise `cpl_err`.
  - Otherwise latch the length and go to **HDR1**.
- **HDR1**:
  - Tag `[43:40]` is checked against the latched tag (see Configuration). A mismatch goes to **DISCARD** and raises `cpl_err`.
  - Otherwise `hold` ← `trn_rd[31:0]`, and the state goes to **DATA**.
- **DATA**: each beat writes `{trn_rd[63:32], hold}` to `qw_ptr`, then `hold` ← `trn_rd[31:0]`, `qw_ptr`++, `dw_cnt` += 2.
  - On the EOF beat (`trn_rrem_n` = `8'h0F`): if `dw_cnt` reaches `CHUNK_DW`, go to **DONE**; else go to **WAIT_SOF**.
  - EOF with `trn_rrem_n` ≠ `8'h0F` is malformed: raise `cpl_err`, go to **WAIT_SOF**. Words already written stay and counters keep their values.
- **DISCARD**: wait for an EOF beat, then return to **WAIT_SOF**.
- **DONE**: `chunk_ready` = 1. `chunk_consumed` goes to **IDLE**. `chunk_arm` is ignored.

Boundary rules:
- `chunk_arm` is ignored outside IDLE.
- `chunk_consumed` is ignored outside DONE.
- Beats with `trn_rsrc_rdy_n` or `trn_rdst_rdy_n` high are not counted.
- Reset at any point returns to IDLE, drops the partial chunk, and zeroes all outputs.

Reset values: `buf_wr_en`=0, `buf_wr_addr`=0, `buf_wr_data`=0, `chunk_ready`=0, `cpl_err`=0.

## Timing
- All outputs are registered.
- A data beat accepted at cycle N produces `buf_wr_en`/addr/data at N+1.
- `cpl_err` pulses at N+1 after the offending beat.
- The final write appears at N+1; `chunk_ready` rises at N+2 so the buffer write has completed.
- `chunk_consumed` at cycle M drops `chunk_ready` at M+1. A `chunk_arm` at M+1 is accepted.
- Back-to-back TLPs (EOF at N, SOF at N+1) are handled without loss.
- Maximum write rate is one QW per cycle.

## Configuration
- `CPL_TAG_CHECK_EN` defined: the HDR1 tag compare is active, and a mismatch discards the TLP with `cpl_err`.
- `CPL_TAG_CHECK_EN` undefined: there is no tag compare, `chunk_tag` is unused, and every CplD passing the QW0 checks is accepted.

## Test plan
- Arm with tag 3, then one CplD of length 128 DW, data DW i = i: 64 writes, addr 0..63, word k = `{2k+1, 2k}`; `chunk_ready` rises 2 cycles after EOF.
- Arm, then 8 CplDs of 16 DW each, back-to-back and with `trn_rsrc_rdy_n` gaps: identical buffer contents; `chunk_ready` only after the 8th.
- CplD with status 3'b001 (UR), then a valid CplD of 128 DW: one `cpl_err`, no writes from the first, chunk completes from the second.
- Tag 5 vs armed tag 3 with `CPL_TAG_CHECK_EN` defined: `cpl_err`, no writes. Without the macro: accepted and written.
- MWr TLP (fmt/type `7'b10_00000`) interleaved between completions: ignored, no `cpl_err`, counts unaffected.
- `reset_n` low for 1 cycle after 20 QWs written: all outputs 0, state IDLE; re-arm plus a full 128 DW CplD completes normally from addr 0.
